// File: rtl/correlation_reader.sv
// correlation_reader
// Captures the packed correlator accumulators into a private shadow copy and
// streams them to the host link as a framed byte sequence over valid/ready.
// Frame: SYNC_BYTE, then lanes from highest index to lowest, each lane sent
// MSB byte first with zero padding above RESOLUTION bits.
// Optional feature: define CORRELATION_READER_CHECKSUM_EN to append a
// trailing XOR checksum byte covering all data bytes (sync byte excluded).
module correlation_reader #(
   parameter int NUM_LANES = 16,
   parameter int RESOLUTION = 24,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_LANES*RESOLUTION-1:0] pulses,
   input  logic                            start,
   output logic                            acc_clear,
   output logic                            busy,
   output logic                            done,
   output logic [7:0]                      tx_data,
   output logic                            tx_valid,
   input  logic                            tx_ready
);

   localparam int BPL = (RESOLUTION + 7) / 8;
   localparam int LANE_BITS = BPL * 8;
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int BYTE_W = (BPL > 1) ? $clog2(BPL) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BPL - 1);

`ifdef CORRELATION_READER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

   state_t state;
   logic [LANE_BITS-1:0] shadow [NUM_LANES];
   logic [LANE_W-1:0] lane_idx;
   logic [BYTE_W-1:0] byte_idx;
   logic [LANE_W-1:0] next_lane;
   logic [BYTE_W-1:0] next_byte;
   logic last_data;
   logic capture;
`ifdef CORRELATION_READER_CHECKSUM_EN
   logic [7:0] csum;
`endif

   // Pick byte b of a zero-padded lane word; b=0 is the least significant byte.
   function automatic logic [7:0] lane_byte(input logic [LANE_BITS-1:0] w,
                                            input logic [BYTE_W-1:0] b);
      return 8'(w >> {b, 3'b000});
   endfunction

   assign capture = (state == IDLE) && start;

   // Snapshot the accumulators; the shadow is deliberately never cleared so
   // the readout is isolated from whatever the correlator does next.
   always_ff @(posedge clk) begin
      if (!reset && capture) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            shadow[k] <= LANE_BITS'(pulses[k*RESOLUTION +: RESOLUTION]);
         end
      end
   end

   // Walk bytes MSB-first within a lane, then step down to the next lane.
   always_comb begin
      next_lane = lane_idx;
      next_byte = byte_idx - 1'b1;
      if (byte_idx == '0) begin
         next_byte = LAST_BYTE;
         next_lane = lane_idx - 1'b1;
      end
      last_data = (lane_idx == '0) && (byte_idx == '0);
   end

   // Frame sequencer; every output is registered and the byte for the next
   // position is loaded on each handshake so tx_data holds during stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx_valid  <= 1'b0;
         tx_data   <= 8'h00;
         acc_clear <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         lane_idx  <= '0;
         byte_idx  <= '0;
`ifdef CORRELATION_READER_CHECKSUM_EN
         csum      <= 8'h00;
`endif
      end else begin
         acc_clear <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SYNC;
                  acc_clear <= 1'b1;
                  busy      <= 1'b1;
                  tx_valid  <= 1'b1;
                  tx_data   <= SYNC_BYTE;
               end
            end
            SYNC: begin
               if (tx_ready) begin
                  state    <= DATA;
                  lane_idx <= LAST_LANE;
                  byte_idx <= LAST_BYTE;
                  tx_data  <= lane_byte(shadow[LAST_LANE], LAST_BYTE);
`ifdef CORRELATION_READER_CHECKSUM_EN
                  csum     <= 8'h00;
`endif
               end
            end
            DATA: begin
               if (tx_ready) begin
`ifdef CORRELATION_READER_CHECKSUM_EN
                  csum <= csum ^ tx_data;
`endif
                  if (last_data) begin
`ifdef CORRELATION_READER_CHECKSUM_EN
                     state   <= CSUM;
                     tx_data <= csum ^ tx_data;
`else
                     state    <= IDLE;
                     tx_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
`endif
                  end else begin
                     lane_idx <= next_lane;
                     byte_idx <= next_byte;
                     tx_data  <= lane_byte(shadow[next_lane], next_byte);
                  end
               end
            end
`ifdef CORRELATION_READER_CHECKSUM_EN
            CSUM: begin
               if (tx_ready) begin
                  state    <= IDLE;
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               tx_valid <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/correlation_reader.md
# correlation_reader

Snapshots the packed accumulator bus produced by the correlator and streams it out as a framed byte sequence over a valid/ready interface toward the host link (UART/USB bridge). On each capture it emits a one-cycle clear request so the correlator starts a new integration period. Transmission runs entirely from a private shadow copy, so a new integration proceeds while the previous one is being read out.

## Interface
- NUM_LANES, 16: number of RESOLUTION-bit accumulator words on `pulses` (baselines × lags × 2, real/imag interleaved).
- RESOLUTION, 24: bits per accumulator word, 1..32.
- SYNC_BYTE, 8'hA5: first byte of every frame.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pulses  in  NUM_LANES*RESOLUTION  packed accumulators; lane k at bits [k*RESOLUTION +: RESOLUTION].
- start  in  1  capture request, level-sampled.
- acc_clear  out  1  one-cycle pulse; drives correlator clear (reset|~enable input).
- busy  out  1  high from capture until the last byte is accepted.
- done  out  1  one-cycle pulse after the last byte is accepted.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid&tx_ready.

## Operation
- BPL = ceil(RESOLUTION/8) bytes per lane. FRAME_BYTES = 1 + NUM_LANES*BPL (+1 with checksum).
- States: IDLE, SYNC, DATA, CSUM (CSUM exists only with the macro).
- IDLE: when start=1, latch `pulses` into the shadow register at that edge, go to SYNC, pulse acc_clear, set busy. While busy, start is ignored.
- SYNC: tx_data=SYNC_BYTE, tx_valid=1. On handshake go to DATA, with lane=NUM_LANES-1 and byte=BPL-1.
- DATA: tx_data = byte `byte` of shadow lane `lane`, so lanes go from highest index to lowest and bytes go MSB-first. Pad bits above RESOLUTION in the top byte are 0. On each handshake, decrement `byte`; when it wraps, decrement `lane`.
- After the final data byte (lane 0, byte 0) is accepted, go to CSUM, or to IDLE if the macro is absent.
- CSUM: tx_data = XOR of all data bytes in the frame (the sync byte is excluded). On handshake go to IDLE.
- tx_data and tx_valid are held stable while tx_valid=1 and tx_ready=0. tx_valid is never deasserted mid-frame.
- Shadow contents are unaffected by later changes on `pulses` until the next capture.

## Timing
- Reset values: tx_valid=0, tx_data=0, acc_clear=0, busy=0, done=0, state=IDLE, lane/byte counters=0. The shadow register is not cleared.
- All outputs are registered.
- start sampled high at edge N:
  - acc_clear=1 and busy=1 during cycle N+1 only for acc_clear.
  - tx_valid=1 with SYNC_BYTE from cycle N+1.
- With tx_ready tied high, one byte transfers per cycle. The last byte is presented in cycle N+FRAME_BYTES.
- done=1 and busy=0 in the cycle after the last handshake.
  - start sampled in that cycle is accepted, giving back-to-back frames with a one-cycle gap.
- Reset asserted mid-frame aborts the frame at the next edge. All outputs return to reset values and a partial frame is not resumed.
- start and reset high together: reset wins; no capture and no acc_clear.
- tx_ready high while tx_valid=0 has no effect.

## Configuration
- CORRELATION_READER_CHECKSUM_EN:
  - Defined: CSUM state is built and the trailing XOR checksum byte is sent.
  - Undefined: frames end after the last data byte, FRAME_BYTES excludes the checksum, and the CSUM logic is absent.

## Test plan
- NUM_LANES=2, RESOLUTION=12, macro on; pulses={12'hABC,12'h123}; start for one cycle; tx_ready=1 -> bytes A5,0A,BC,01,23,94 on consecutive cycles starting at N+1; acc_clear for one cycle at N+1; done at N+7.
- Same stimulus, pulses changed to all-ones at N+2 -> emitted bytes unchanged (shadow isolation).
- Same frame with tx_ready toggling 1,0,0,1,… -> identical byte sequence; tx_data stable during stalls; no byte duplicated or dropped.
- start held high continuously -> consecutive frames separated by exactly one idle cycle; acc_clear once per frame; start during busy ignored.
- Reset asserted on the 3rd data byte -> tx_valid=0 next cycle, busy=0, no done; a subsequent start produces a full fresh frame.
- Macro off, defaults (16 lanes, RESOLUTION=24), lane k = k -> 49 bytes; last three bytes 00,00,00; top byte of lane 15 is 00, then 00, then 0F.
